rs_alu_sched: RTL and testbench

Allocation/issue scheduler for the 2-wide ALU reservation station. It picks up to two free entries for the decoder's two ALU ops per cycle. It also picks up to two operand-ready entries for issue, strictly oldest-first, using a registered age matrix. It produces the station-full stall request and keeps an occupancy counter that must track the station's busy vector.

---
 rtl/rs_alu_sched.sv | 151 +++++++++++++++
 tb/tb_rs_alu_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rs_alu_sched.sv
// Allocation/issue scheduler for the 2-wide ALU reservation station: picks free
// entries for two decoder ops and the two oldest operand-ready entries for issue.
module rs_alu_sched #(
    parameter int RS_SIZE = 7,
    parameter int SEL_W   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_rdy,
    input  logic               i_clear,
    input  logic               i_stall,
    input  logic               i_alloc_req_1,
    input  logic               i_alloc_req_2,
    input  logic [RS_SIZE-1:0] i_busy,
    input  logic [RS_SIZE-1:0] i_ready_n,
    output logic [SEL_W-1:0]   o_alloc_addr_1,
    output logic [SEL_W-1:0]   o_alloc_addr_2,
    output logic [SEL_W-1:0]   o_issue_addr_1,
    output logic [SEL_W-1:0]   o_issue_addr_2,
    output logic               o_rs_full,
    output logic [SEL_W:0]     o_occupancy
);

    localparam logic [SEL_W-1:0] NONE  = '1;
    localparam int               OCC_W = SEL_W + 1;

    function automatic logic [SEL_W-1:0] f_lowest(input logic [RS_SIZE-1:0] v);
        logic [SEL_W-1:0] r;
        r = NONE;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (v[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    function automatic logic [RS_SIZE-1:0] f_onehot(input logic [SEL_W-1:0] a);
        logic [RS_SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (a == SEL_W'(i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [OCC_W-1:0] f_popcnt(input logic [RS_SIZE-1:0] v);
        logic [OCC_W-1:0] r;
        r = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            r = r + OCC_W'(v[i]);
        end
        return r;
    endfunction

    // A candidate is oldest when no other candidate has its older bit set over it.
    function automatic logic [SEL_W-1:0] f_oldest(input logic [RS_SIZE-1:0] cand,
                                                  input logic [RS_SIZE-1:0][RS_SIZE-1:0] older);
        logic [RS_SIZE-1:0] top;
        top = cand;
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (cand[j] && older[j][i]) top[i] = 1'b0;
            end
        end
        return f_lowest(top);
    endfunction

    logic [RS_SIZE-1:0][RS_SIZE-1:0] r_older;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] w_older_nxt;
    logic [OCC_W-1:0]                r_occ;
    logic [OCC_W-1:0]                w_occ_nxt;

    logic [RS_SIZE-1:0] w_free;
    logic [RS_SIZE-1:0] w_ready;
    logic [RS_SIZE-1:0] w_oh1;
    logic [RS_SIZE-1:0] w_oh2;
    logic [OCC_W-1:0]   w_nfree;
    logic [OCC_W-1:0]   w_nreq;
    logic [OCC_W-1:0]   w_n_alloc;
    logic [OCC_W-1:0]   w_n_issue;
    logic [SEL_W-1:0]   w_slot1;
    logic [SEL_W-1:0]   w_slot2;
    logic [SEL_W-1:0]   w_a1;
    logic [SEL_W-1:0]   w_a2;
    logic [SEL_W-1:0]   w_i1;
    logic [SEL_W-1:0]   w_i2;
    logic               w_full;
    logic               w_issue_en;
    logic               w_commit;
    int                 w_occ_sum;

    always_comb begin
        w_free     = ~i_busy;
        w_nfree    = f_popcnt(w_free);
        w_nreq     = OCC_W'(i_alloc_req_1) + OCC_W'(i_alloc_req_2);
        w_full     = (w_nreq > w_nfree);
        w_slot1    = f_lowest(w_free);
        w_slot2    = f_lowest(w_free & ~f_onehot(w_slot1));
        w_a1       = (i_alloc_req_1 && !w_full) ? w_slot1 : NONE;
        w_a2       = (i_alloc_req_2 && !w_full) ? (i_alloc_req_1 ? w_slot2 : w_slot1) : NONE;
        w_issue_en = i_rdy && !i_clear;
        w_ready    = ~i_ready_n & i_busy;
        w_i1       = w_issue_en ? f_oldest(w_ready, r_older) : NONE;
        w_i2       = w_issue_en ? f_oldest(w_ready & ~f_onehot(w_i1), r_older) : NONE;
        w_commit   = i_rdy && !i_stall && !w_full && !i_clear;
        w_oh1      = (w_commit && i_alloc_req_1) ? f_onehot(w_a1) : '0;
        w_oh2      = (w_commit && i_alloc_req_2) ? f_onehot(w_a2) : '0;
        w_n_alloc  = w_commit ? w_nreq : '0;
        w_n_issue  = OCC_W'(w_i1 != NONE) + OCC_W'(w_i2 != NONE);
    end

    // New entries become younger than everything busy; slot 1 outranks slot 2.
    always_comb begin
        w_older_nxt = r_older;
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (w_oh1[i] || w_oh2[i]) w_older_nxt[i][j] = 1'b0;
                if ((w_oh1[j] || w_oh2[j]) && i_busy[i]) w_older_nxt[i][j] = 1'b1;
                if (w_oh1[i] && w_oh2[j]) w_older_nxt[i][j] = 1'b1;
                if (i == j) w_older_nxt[i][j] = 1'b0;
            end
        end
    end

    always_comb begin
        w_occ_sum = int'(r_occ) + int'(w_n_alloc) - int'(w_n_issue);
        if (w_occ_sum < 0) w_occ_sum = 0;
        else if (w_occ_sum > RS_SIZE) w_occ_sum = RS_SIZE;
        w_occ_nxt = OCC_W'(w_occ_sum);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_older <= '0;
            r_occ   <= '0;
        end else if (i_clear) begin
            r_older <= '0;
            r_occ   <= '0;
        end else if (i_rdy) begin
            r_older <= w_older_nxt;
            r_occ   <= w_occ_nxt;
        end
    end

    assign o_alloc_addr_1 = i_rst_n ? w_a1 : NONE;
    assign o_alloc_addr_2 = i_rst_n ? w_a2 : NONE;
    assign o_issue_addr_1 = i_rst_n ? w_i1 : NONE;
    assign o_issue_addr_2 = i_rst_n ? w_i2 : NONE;
    assign o_rs_full      = i_rst_n && w_full;
    assign o_occupancy    = r_occ;

endmodule

// File: tb/tb_rs_alu_sched.sv
// Directed scoreboard bench for rs_alu_sched; the driver models the station's
// busy vector by hand and pushes hand-computed expected outputs per cycle.
module tb_rs_alu_sched;

    localparam int W = 17;

    logic       clk;
    logic       rst_n;
    logic       rdy;
    logic       clear;
    logic       stall;
    logic       req1;
    logic       req2;
    logic [6:0] busy;
    logic [6:0] ready_n;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [2:0] i1;
    logic [2:0] i2;
    logic       full;
    logic [3:0] occ;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         chk_en;
    int           n_chk;
    int           n_pass;

    rs_alu_sched dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rdy          (rdy),
        .i_clear        (clear),
        .i_stall        (stall),
        .i_alloc_req_1  (req1),
        .i_alloc_req_2  (req2),
        .i_busy         (busy),
        .i_ready_n      (ready_n),
        .o_alloc_addr_1 (a1),
        .o_alloc_addr_2 (a2),
        .o_issue_addr_1 (i1),
        .o_issue_addr_2 (i2),
        .o_rs_full      (full),
        .o_occupancy    (occ)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: samples on the falling edge, pops one expected record per checked cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [W-1:0] got;
            logic [W-1:0] exp;
            string        nm;
            got = {a1, a2, i1, i2, full, occ};
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL underflow got=%h exp=<empty queue>", got);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (got === exp) n_pass++;
                else $display("FAIL %s got a1=%0d a2=%0d i1=%0d i2=%0d full=%0d occ=%0d exp a1=%0d a2=%0d i1=%0d i2=%0d full=%0d occ=%0d",
                              nm, got[16:14], got[13:11], got[10:8], got[7:5], got[4], got[3:0],
                              exp[16:14], exp[13:11], exp[10:8], exp[7:5], exp[4], exp[3:0]);
            end
        end
    end

    // Driver: one cycle of stimulus plus its expected outputs.
    task automatic step(input string nm, input logic rn, input logic rd, input logic cl,
                        input logic st, input logic q1, input logic q2,
                        input logic [6:0] b, input logic [6:0] rn_v,
                        input logic [2:0] e_a1, input logic [2:0] e_a2,
                        input logic [2:0] e_i1, input logic [2:0] e_i2,
                        input logic e_f, input logic [3:0] e_o);
        rst_n   = rn;
        rdy     = rd;
        clear   = cl;
        stall   = st;
        req1    = q1;
        req2    = q2;
        busy    = b;
        ready_n = rn_v;
        exp_q.push_back({e_a1, e_a2, e_i1, e_i2, e_f, e_o});
        name_q.push_back(nm);
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b0;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        chk_en  = 1'b0;
        rst_n   = 1'b0;
        rdy     = 1'b1;
        clear   = 1'b0;
        stall   = 1'b0;
        req1    = 1'b0;
        req2    = 1'b0;
        busy    = '0;
        ready_n = '1;
        @(posedge clk);
        #1;
        //         name          rn rd cl st q1 q2 busy        ready_n      a1 a2 i1 i2 f occ
        step("reset_outputs",   0, 1, 0, 0, 1, 1, 7'b0000000, 7'b1111111, 7, 7, 7, 7, 0, 0);
        step("alloc_dual",      1, 1, 0, 0, 1, 1, 7'b0000000, 7'b1111111, 0, 1, 7, 7, 0, 0);
        step("occ_two_issue",   1, 1, 0, 0, 0, 0, 7'b0000011, 7'b1111100, 7, 7, 0, 1, 0, 2);
        step("occ_back_zero",   1, 1, 0, 0, 0, 0, 7'b0000000, 7'b1111111, 7, 7, 7, 7, 0, 0);
        step("fill_01",         1, 1, 0, 0, 1, 1, 7'b0000000, 7'b1111111, 0, 1, 7, 7, 0, 0);
        step("fill_2",          1, 1, 0, 0, 1, 0, 7'b0000011, 7'b1111111, 2, 7, 7, 7, 0, 2);
        step("alloc_3_iss_1",   1, 1, 0, 0, 1, 0, 7'b0000111, 7'b1111101, 3, 7, 1, 7, 0, 3);
        step("alloc_1_and_4",   1, 1, 0, 0, 1, 1, 7'b0001101, 7'b1111111, 1, 4, 7, 7, 0, 3);
        step("alloc_5",         1, 1, 0, 0, 1, 0, 7'b0011111, 7'b1111111, 5, 7, 7, 7, 0, 5);
        step("issue_3_then_1",  1, 1, 0, 0, 0, 0, 7'b0111111, 7'b1010101, 7, 7, 3, 1, 0, 6);
        step("issue_5_only",    1, 1, 0, 0, 0, 0, 7'b0110101, 7'b1011111, 7, 7, 5, 7, 0, 4);
        step("full_both_req",   1, 1, 0, 0, 1, 1, 7'b1111110, 7'b1111111, 7, 7, 7, 7, 1, 3);
        step("full_drop_req2",  1, 1, 0, 1, 1, 0, 7'b1111110, 7'b1111111, 0, 7, 7, 7, 0, 3);
        step("req2_only",       1, 1, 0, 1, 0, 1, 7'b0010101, 7'b1111111, 7, 1, 7, 7, 0, 3);
        step("alloc_iss_net",   1, 1, 0, 0, 1, 1, 7'b0010101, 7'b1101011, 1, 3, 2, 4, 0, 3);
        step("alloc_2_4_net",   1, 1, 0, 0, 1, 1, 7'b0001011, 7'b1111100, 2, 4, 0, 1, 0, 3);
        step("issue_2_before_4",1, 1, 0, 0, 0, 0, 7'b0011100, 7'b1101011, 7, 7, 2, 4, 0, 3);
        step("stall_no_commit", 1, 1, 0, 1, 1, 0, 7'b0001000, 7'b1111111, 0, 7, 7, 7, 0, 1);
        step("rdy0_freeze",     1, 0, 0, 0, 1, 0, 7'b0001000, 7'b1110111, 0, 7, 7, 7, 0, 1);
        step("after_freeze",    1, 1, 0, 0, 1, 1, 7'b0001000, 7'b1111111, 0, 1, 7, 7, 0, 1);
        step("fill_five",       1, 1, 0, 0, 1, 1, 7'b0001011, 7'b1111111, 2, 4, 7, 7, 0, 3);
        step("clear_cycle",     1, 0, 1, 0, 1, 0, 7'b0011111, 7'b1111100, 5, 7, 7, 7, 0, 5);
        step("after_clear",     1, 1, 0, 0, 0, 0, 7'b0000000, 7'b1111111, 7, 7, 7, 7, 0, 0);
        step("alloc_pre_rst",   1, 1, 0, 0, 1, 0, 7'b0000000, 7'b1111111, 0, 7, 7, 7, 0, 0);
        step("async_rst_mid",   0, 1, 0, 0, 1, 1, 7'b1111111, 7'b0000000, 7, 7, 7, 7, 0, 0);
        step("post_rst_alloc",  1, 1, 0, 0, 1, 1, 7'b0000000, 7'b1111111, 0, 1, 7, 7, 0, 0);
        step("post_rst_issue",  1, 1, 0, 0, 0, 0, 7'b0000011, 7'b1111100, 7, 7, 0, 1, 0, 2);
        repeat (2) @(posedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain got=%0d pending exp=0 pending", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
